// File: rtl/stage_id.sv
// RV32I instruction decode stage: register read, operand hazard check against
// in-flight writes, immediate generation, branch/jump resolution back to fetch.
// Optional illegal-instruction trap: define ILLEGAL_INST_EN.
module stage_id (
  input  logic        clk,
  input  logic        rst,
  input  logic        Done_I,
  input  logic [31:0] IR_I,
  input  logic [31:0] PC_I,
  output logic        Stall_O,
  output logic        Feedback_Branch,
  output logic [31:0] next_PC,
  output logic [4:0]  RF_raddr1,
  output logic [4:0]  RF_raddr2,
  input  logic [31:0] RF_rdata1,
  input  logic [31:0] RF_rdata2,
  input  logic [31:0] Pending_Wr,
  output logic        Valid_O,
  input  logic        EX_Ready,
  output logic [31:0] PC_O,
  output logic [31:0] IR_O,
  output logic [31:0] Imm_O,
  output logic [31:0] RS1_Val,
  output logic [31:0] RS2_Val,
  output logic [4:0]  Rd_O,
  output logic        Illegal_O
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    s_IDLE = 4'b0001,
    s_HAZ  = 4'b0010,
    s_OUT  = 4'b0100,
    s_ERR  = 4'b1000
  } state_t;

  typedef struct packed {
    logic lui, auipc, jal, jalr, branch, load, store, opimm, op;
  } dec_t;

  state_t      state, state_nxt;
  logic [31:0] ir_q, pc_q;
  logic        capture;
  dec_t        dec;
  logic [4:0]  rs1, rs2;
  logic [2:0]  funct3;
  logic        use_rs1, use_rs2, hazard, illegal;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic        cond, taken;
  logic [31:0] target;

  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct3 = ir_q[14:12];

  always_comb begin
    dec        = '0;
    dec.lui    = (ir_q[6:0] == OPC_LUI);
    dec.auipc  = (ir_q[6:0] == OPC_AUIPC);
    dec.jal    = (ir_q[6:0] == OPC_JAL);
    dec.jalr   = (ir_q[6:0] == OPC_JALR);
    dec.branch = (ir_q[6:0] == OPC_BRANCH);
    dec.load   = (ir_q[6:0] == OPC_LOAD);
    dec.store  = (ir_q[6:0] == OPC_STORE);
    dec.opimm  = (ir_q[6:0] == OPC_OPIMM);
    dec.op     = (ir_q[6:0] == OPC_OP);
  end

  assign use_rs1 = !(dec.lui || dec.auipc || dec.jal);
  assign use_rs2 = dec.branch || dec.store || dec.op;
  // x0 never has a real pending write, so its scoreboard bit is ignored
  assign hazard  = (use_rs1 && (rs1 != 5'd0) && Pending_Wr[rs1]) ||
                   (use_rs2 && (rs2 != 5'd0) && Pending_Wr[rs2]);

`ifdef ILLEGAL_INST_EN
  assign illegal = !(|dec) || (dec.branch && (funct3[2:1] == 2'b01));
`else
  assign illegal = 1'b0;
`endif

  // Immediate formats
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    imm = '0;
    if (dec.jalr || dec.load || dec.opimm) imm = imm_i;
    else if (dec.store)                    imm = imm_s;
    else if (dec.branch)                   imm = imm_b;
    else if (dec.lui || dec.auipc)         imm = imm_u;
    else if (dec.jal)                      imm = imm_j;
  end

  assign RF_raddr1 = rs1;
  assign RF_raddr2 = rs2;
  assign RS1_Val   = (rs1 == 5'd0) ? 32'd0 : RF_rdata1;
  assign RS2_Val   = (rs2 == 5'd0) ? 32'd0 : RF_rdata2;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (RS1_Val == RS2_Val);
      3'b001:  cond = (RS1_Val != RS2_Val);
      3'b100:  cond = ($signed(RS1_Val) <  $signed(RS2_Val));
      3'b101:  cond = ($signed(RS1_Val) >= $signed(RS2_Val));
      3'b110:  cond = (RS1_Val <  RS2_Val);
      3'b111:  cond = (RS1_Val >= RS2_Val);
      default: cond = 1'b0;
    endcase
  end

  // imm already carries the J/B format for JAL/BRANCH, I for JALR
  assign target = dec.jalr ? ((RS1_Val + imm) & ~32'd1) : (pc_q + imm);
  // Only s_OUT may redirect: RF data is not trustworthy until the hazard clears
  assign taken  = (state == s_OUT) && (dec.jal || dec.jalr || (dec.branch && cond));

  assign Feedback_Branch = taken;
  assign next_PC         = taken ? target : 32'd0;

  assign Stall_O = (state != s_IDLE) && !((state == s_OUT) && EX_Ready);
  assign capture = Done_I && !Stall_O;
  assign Valid_O = (state == s_OUT);

`ifdef ILLEGAL_INST_EN
  assign Illegal_O = (state == s_ERR);
`else
  assign Illegal_O = 1'b0;
`endif

  assign PC_O  = pc_q;
  assign IR_O  = ir_q;
  assign Imm_O = imm;
  assign Rd_O  = (dec.lui || dec.auipc || dec.jal || dec.jalr || dec.load ||
                  dec.opimm || dec.op) ? ir_q[11:7] : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_IDLE;
      ir_q  <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ir_q <= IR_I;
        pc_q <= PC_I;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      s_IDLE: if (capture) state_nxt = s_HAZ;
      s_HAZ: begin
        if (illegal)      state_nxt = s_ERR;
        else if (!hazard) state_nxt = s_OUT;
      end
      s_OUT: if (EX_Ready) state_nxt = capture ? s_HAZ : s_IDLE;
      s_ERR:   state_nxt = s_ERR;
      default: state_nxt = s_IDLE;
    endcase
  end

endmodule
